mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port synchronous LC-3 main memory (16-bit address, 16-bit data, one-cycle read latency). Port 0 serves the CPU fetch/data path. Port 1 serves a loader/debug engine. The block selects one request per cycle, drives the memory enable, read/write and address/data lines, and routes the registered read data back to the owning requester. Port 1 may lock the memory for bursts, bounded by a fairness limit.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_if
// Brief   : Two requester ports plus the single-port memory bus for mem_arbiter
// Rev     : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;
  logic              lock1;

  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  // Arbiter side
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, lock1, mem_dout,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           mem_en, mem_rw, mem_addr, mem_din
  );

  // Requesters and memory side
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, lock1, mem_dout,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
           mem_en, mem_rw, mem_addr, mem_din
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Round-robin arbiter with port-1 lock for single-port LC-3 memory
// Rev     : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int                 c_CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [c_CNT_W-1:0] c_MAX_HOLD = c_CNT_W'(MAX_HOLD);

  logic               r_last_gnt;
  logic [c_CNT_W-1:0] r_hold_cnt;
  logic               r_tag_vld;
  logic               r_tag_port;

  logic               w_lock_win;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_rw;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_din;

  // Lock only extends an ownership port 1 already holds, and only below the limit
  assign w_lock_win = r_last_gnt && bus.lock1 && bus.req1 && (r_hold_cnt < c_MAX_HOLD);

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (w_lock_win) begin
        w_gnt1 = 1'b1;
      end else if (bus.req0 && bus.req1) begin
        w_gnt0 = r_last_gnt;
        w_gnt1 = !r_last_gnt;
      end else begin
        w_gnt0 = bus.req0;
        w_gnt1 = bus.req1;
      end
    end
  end

  always_comb begin
    w_rw   = 1'b0;
    w_addr = '0;
    w_din  = '0;
    if (w_gnt0) begin
      w_rw   = bus.we0;
      w_addr = bus.addr0;
      w_din  = bus.wdata0;
    end else if (w_gnt1) begin
      w_rw   = bus.we1;
      w_addr = bus.addr1;
      w_din  = bus.wdata1;
    end
  end

  assign bus.gnt0     = w_gnt0;
  assign bus.gnt1     = w_gnt1;
  assign bus.mem_en   = w_gnt0 | w_gnt1;
  assign bus.mem_rw   = w_rw;
  assign bus.mem_addr = w_addr;
  assign bus.mem_din  = w_din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= 1'b1;
      r_hold_cnt <= '0;
      r_tag_vld  <= 1'b0;
      r_tag_port <= 1'b0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_last_gnt <= w_gnt1;
        r_tag_vld  <= !w_rw;
        r_tag_port <= w_gnt1;
      end else begin
        r_tag_vld  <= 1'b0;
      end

      // Only locked grants taken against a waiting port 0 count toward fairness
      if (w_gnt1 && bus.req0 && bus.lock1) begin
        if (r_hold_cnt != c_MAX_HOLD) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end else if (w_gnt0 || !bus.lock1 || !(w_gnt0 || w_gnt1)) begin
        r_hold_cnt <= '0;
      end
    end
  end

  // Memory read data arrives one cycle after the access; steer it by the tag
  assign bus.rvalid0 = r_tag_vld && !r_tag_port;
  assign bus.rvalid1 = r_tag_vld && r_tag_port;
  assign bus.rdata0  = bus.rvalid0 ? bus.mem_dout : '0;
  assign bus.rdata1  = bus.rvalid1 ? bus.mem_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed self-checking bench for mem_arbiter with a memory model
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] exp6 [4];
  logic [10:0] pat;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory, one-cycle read latency
  initial begin
    bus.mem_dout <= 16'h0;
    mem[16'h0000] <= 16'h5260;
    mem[16'h0001] <= 16'h1265;
    mem[16'h0002] <= 16'h03FE;
    mem[16'h0003] <= 16'h1265;
    mem[16'h0004] <= 16'h0004;
    mem[16'hFFFF] <= 16'h1234;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_rw) mem[bus.mem_addr] <= bus.mem_din;
        else            bus.mem_dout      <= mem[bus.mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1,
                       input logic lk);
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    bus.lock1 = lk;
    #1;
  endtask

  initial begin
    exp6[0] = 16'h5260; exp6[1] = 16'h1265; exp6[2] = 16'h03FE; exp6[3] = 16'h1265;
    pat = 11'b11111011110;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // Outputs held at zero while in reset
    drive(1, 0, 16'h0005, 0, 1, 0, 16'h0002, 0, 0);
    check("rst_gnt0",   32'(bus.gnt0), 0);
    check("rst_gnt1",   32'(bus.gnt1), 0);
    check("rst_mem_en", 32'(bus.mem_en), 0);
    check("rst_addr",   32'(bus.mem_addr), 0);
    check("rst_rvalid0", 32'(bus.rvalid0), 0);
    check("rst_rdata0", 32'(bus.rdata0), 0);

    // Single read from port 0
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    check("t1_gnt0",   32'(bus.gnt0), 1);
    check("t1_gnt1",   32'(bus.gnt1), 0);
    check("t1_mem_en", 32'(bus.mem_en), 1);
    check("t1_mem_rw", 32'(bus.mem_rw), 0);
    check("t1_addr",   32'(bus.mem_addr), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_rvalid0", 32'(bus.rvalid0), 1);
    check("t1_rdata0",  32'(bus.rdata0), 32'h5260);
    check("t1_rvalid1", 32'(bus.rvalid1), 0);
    check("t1_idle_en", 32'(bus.mem_en), 0);

    // Streaming reads from port 0
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) drive(1, 0, 16'(k), 0, 0, 0, 0, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (k < 4) begin
        check("t6_gnt0", 32'(bus.gnt0), 1);
        check("t6_addr", 32'(bus.mem_addr), 32'(k));
      end
      if (k == 0) begin
        check("t6_rvalid0_first", 32'(bus.rvalid0), 0);
      end else begin
        check("t6_rvalid0", 32'(bus.rvalid0), 1);
        check("t6_rdata0",  32'(bus.rdata0), 32'(exp6[k-1]));
      end
    end

    // Port 1 write then port 0 read of the same word
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 16'h3000, 16'hABCD, 0);
    check("t3_gnt1", 32'(bus.gnt1), 1);
    check("t3_gnt0", 32'(bus.gnt0), 0);
    check("t3_rw",   32'(bus.mem_rw), 1);
    check("t3_addr", 32'(bus.mem_addr), 32'h3000);
    check("t3_din",  32'(bus.mem_din), 32'hABCD);
    @(negedge clk);
    drive(1, 0, 16'h3000, 0, 0, 0, 0, 0, 0);
    check("t3_rd_gnt0", 32'(bus.gnt0), 1);
    check("t3_wr_no_rvalid1", 32'(bus.rvalid1), 0);
    check("t3_wr_no_rvalid0", 32'(bus.rvalid0), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 16'hFFFF, 0, 0);
    check("t3_rvalid0", 32'(bus.rvalid0), 1);
    check("t3_rdata0",  32'(bus.rdata0), 32'hABCD);
    check("t3_rvalid1", 32'(bus.rvalid1), 0);
    check("top_gnt1",   32'(bus.gnt1), 1);
    check("top_addr",   32'(bus.mem_addr), 32'hFFFF);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("top_rvalid1", 32'(bus.rvalid1), 1);
    check("top_rdata1",  32'(bus.rdata1), 32'h1234);
    check("top_rvalid0", 32'(bus.rvalid0), 0);

    // Reset right after a port 0 read grant drops the response
    @(negedge clk);
    drive(1, 0, 16'h0001, 0, 0, 0, 0, 0, 0);
    check("t5_gnt0", 32'(bus.gnt0), 1);
    #2 rst = 1'b1;
    @(negedge clk);
    drive(1, 0, 16'h0000, 0, 1, 0, 16'h0002, 0, 0);
    check("t5_rvalid0", 32'(bus.rvalid0), 0);
    check("t5_rdata0",  32'(bus.rdata0), 0);
    check("t5_gnt0",    32'(bus.gnt0), 0);
    check("t5_gnt1",    32'(bus.gnt1), 0);
    check("t5_mem_en",  32'(bus.mem_en), 0);
    check("t5_mem_addr", 32'(bus.mem_addr), 0);

    // Both reading, no lock: strict alternation starting with port 0
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 16'h0000, 0, 1, 0, 16'h0002, 0, 0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      check("t2_gnt0", 32'(bus.gnt0), 32'(k % 2 == 0));
      check("t2_gnt1", 32'(bus.gnt1), 32'(k % 2 == 1));
      if (k == 0) begin
        check("t2_rvalid0_first", 32'(bus.rvalid0), 0);
        check("t2_rvalid1_first", 32'(bus.rvalid1), 0);
      end else if ((k - 1) % 2 == 0) begin
        check("t2_rvalid0", 32'(bus.rvalid0), 1);
        check("t2_rdata0",  32'(bus.rdata0), 32'h5260);
        check("t2_rvalid1_off", 32'(bus.rvalid1), 0);
      end else begin
        check("t2_rvalid1", 32'(bus.rvalid1), 1);
        check("t2_rdata1",  32'(bus.rdata1), 32'h03FE);
        check("t2_rvalid0_off", 32'(bus.rvalid0), 0);
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_last_rvalid1", 32'(bus.rvalid1), 1);
    check("t2_last_rdata1",  32'(bus.rdata1), 32'h03FE);

    // Locked port 1 burst bounded by MAX_HOLD=4
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 16'h0004, 0, 1);
    check("t4_gnt1_solo", 32'(bus.gnt1), 32'(pat[10]));
    check("t4_gnt0_solo", 32'(bus.gnt0), 0);
    for (int k = 1; k < 11; k++) begin
      @(negedge clk);
      drive(1, 0, 16'h0000, 0, 1, 0, 16'h0004, 0, 1);
      check("t4_gnt1", 32'(bus.gnt1), 32'(pat[10-k]));
      check("t4_gnt0", 32'(bus.gnt0), 32'(!pat[10-k]));
      check("t4_rvalid1", 32'(bus.rvalid1), 32'(pat[11-k]));
      check("t4_rvalid0", 32'(bus.rvalid0), 32'(!pat[11-k]));
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_end_rvalid0", 32'(bus.rvalid0), 1);
    check("t4_end_rdata0",  32'(bus.rdata0), 32'h5260);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
